uart_fifo_ctrl: RTL and testbench

Memory-mapped controller that sits between the CPU's UART MMIO decode (0x8000_00xx) and the on-chip uart block.
- Buffers transmit bytes in a TX FIFO and received bytes in an RX FIFO.
- Drives the uart data_in/data_out ready-valid handshakes.
- Exposes status, data and control registers to CPU loads and stores.
- Decouples software polling from the bit-level UART timing, so back-to-back sw to TX data no longer spin on tx ready.

---
 rtl/uart_ctrl_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/uart_fifo_ctrl.sv | 117 +++++++++++
 tb/tb_uart_fifo_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared register map and bit positions for the UART MMIO controller.
package uart_ctrl_pkg;

   localparam logic [7:0] UART_STATUS = 8'h00;
   localparam logic [7:0] UART_RXDATA = 8'h04;
   localparam logic [7:0] UART_TXDATA = 8'h08;
   localparam logic [7:0] UART_CTRL   = 8'h0C;

   // STATUS bit positions
   localparam int unsigned ST_TX_NFULL  = 0;
   localparam int unsigned ST_RX_NEMPTY = 1;
   localparam int unsigned ST_RX_OVF    = 2;
   localparam int unsigned ST_TX_DROP   = 3;
   localparam int unsigned ST_TXCNT_LSB = 8;
   localparam int unsigned ST_RXCNT_LSB = 16;
   localparam int unsigned ST_CNT_W     = 8;

   // CTRL bit positions
   localparam int unsigned CTRL_CLEAR = 0;
   localparam int unsigned CTRL_FLUSH = 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with guarded push/pop and a flush that overrides both.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_pop;
   logic             w_do_push;

   assign full      = (r_count == CNT_W'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign head      = r_mem[r_rd_ptr];
   assign w_do_pop  = pop && !empty;
   // A push into a full FIFO is still taken when a pop frees a slot the same cycle
   assign w_do_push = push && (!full || w_do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; contents are meaningless until written.
   always_ff @(posedge clk) begin
      if (w_do_push && !flush) r_mem[r_wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// CPU-facing UART controller: TX/RX FIFOs, status/data/control registers and
// the uart ready-valid handshakes.
module uart_fifo_ctrl
   import uart_ctrl_pkg::*;
#(
   parameter int unsigned TX_DEPTH = 8,
   parameter int unsigned RX_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [7:0]  req_addr,
   input  logic [7:0]  req_wdata,
   output logic [31:0] rdata,
   output logic [7:0]  uart_tx_data,
   output logic        uart_tx_valid,
   input  logic        uart_tx_ready,
   input  logic [7:0]  uart_rx_data,
   input  logic        uart_rx_valid,
   output logic        uart_rx_ready,
   output logic        irq_rx
);

   localparam int unsigned TX_CNT_W = $clog2(TX_DEPTH) + 1;
   localparam int unsigned RX_CNT_W = $clog2(RX_DEPTH) + 1;

   logic                w_load, w_store, w_flush, w_clear;
   logic                w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
   logic                w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
   logic [7:0]          w_rx_head;
   logic [TX_CNT_W-1:0] w_tx_count;
   logic [RX_CNT_W-1:0] w_rx_count;
   logic [31:0]         w_status;
   logic                w_ovf_set, w_drop_set;
   logic                r_rx_overflow, r_tx_drop;

   assign w_load    = req_valid && !req_we;
   assign w_store   = req_valid && req_we;
   assign w_flush   = w_store && (req_addr == UART_CTRL) && req_wdata[CTRL_FLUSH];
   assign w_clear   = w_store && (req_addr == UART_CTRL) && req_wdata[CTRL_CLEAR];

   assign w_tx_push = w_store && (req_addr == UART_TXDATA);
   assign w_tx_pop  = uart_tx_valid && uart_tx_ready;
   assign w_rx_pop  = w_load && (req_addr == UART_RXDATA) && !w_rx_empty;
   assign w_rx_push = uart_rx_valid && uart_rx_ready;

   assign uart_tx_valid = !w_tx_empty;
   assign uart_rx_ready = !w_rx_full || w_rx_pop;
   assign irq_rx        = !w_rx_empty;

   // A flushed push is discarded silently, so it cannot raise tx_drop
   assign w_drop_set = w_tx_push && w_tx_full && !w_tx_pop && !w_flush;
   assign w_ovf_set  = uart_rx_valid && !uart_rx_ready;

   sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_tx_push),
      .pop   (w_tx_pop),
      .flush (w_flush),
      .din   (req_wdata),
      .head  (uart_tx_data),
      .count (w_tx_count),
      .full  (w_tx_full),
      .empty (w_tx_empty)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_rx_push),
      .pop   (w_rx_pop),
      .flush (w_flush),
      .din   (uart_rx_data),
      .head  (w_rx_head),
      .count (w_rx_count),
      .full  (w_rx_full),
      .empty (w_rx_empty)
   );

   always_comb begin
      w_status                              = '0;
      w_status[ST_TX_NFULL]                 = !w_tx_full;
      w_status[ST_RX_NEMPTY]                = !w_rx_empty;
      w_status[ST_RX_OVF]                   = r_rx_overflow;
      w_status[ST_TX_DROP]                  = r_tx_drop;
      w_status[ST_TXCNT_LSB +: ST_CNT_W]    = ST_CNT_W'(w_tx_count);
      w_status[ST_RXCNT_LSB +: ST_CNT_W]    = ST_CNT_W'(w_rx_count);
   end

   // Sticky flags: a new event in the same cycle as a clear keeps the flag set
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_overflow <= 1'b0;
         r_tx_drop     <= 1'b0;
      end else begin
         if (w_ovf_set)     r_rx_overflow <= 1'b1;
         else if (w_clear)  r_rx_overflow <= 1'b0;
         if (w_drop_set)    r_tx_drop     <= 1'b1;
         else if (w_clear)  r_tx_drop     <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (w_load) begin
         case (req_addr)
            UART_STATUS: rdata <= w_status;
            UART_RXDATA: rdata <= w_rx_empty ? 32'h0 : {24'h0, w_rx_head};
            default:     rdata <= 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed self-checking bench for uart_fifo_ctrl with default 8-deep FIFOs.
module tb_uart_fifo_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [7:0]  req_addr;
   logic [7:0]  req_wdata;
   logic [31:0] rdata;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_valid;
   logic        uart_tx_ready;
   logic [7:0]  uart_rx_data;
   logic        uart_rx_valid;
   logic        uart_rx_ready;
   logic        irq_rx;

   int checks   = 0;
   int failures = 0;

   uart_fifo_ctrl #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_we        (req_we),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .rdata         (rdata),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_valid (uart_tx_valid),
      .uart_tx_ready (uart_tx_ready),
      .uart_rx_data  (uart_rx_data),
      .uart_rx_valid (uart_rx_valid),
      .uart_rx_ready (uart_rx_ready),
      .irq_rx        (irq_rx)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not complete");
   end

   // Bus drivers: called at a negedge, return at the next negedge.
   task automatic cpu_load(input logic [7:0] a, output logic [31:0] d);
      req_valid = 1'b1; req_we = 1'b0; req_addr = a;
      @(negedge clk);
      req_valid = 1'b0;
      d = rdata;
   endtask

   task automatic cpu_store(input logic [7:0] a, input logic [7:0] wd);
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'b0;
   endtask

   task automatic rx_send(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         uart_rx_valid = 1'b1;
         uart_rx_data  = first + 8'(i);
         @(negedge clk);
      end
      uart_rx_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst = 1'b1;
      req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
      uart_tx_ready = 0; uart_rx_valid = 0; uart_rx_data = 0;
      repeat (2) @(negedge clk);
      checks++;
      if (rdata !== 32'h0 || uart_tx_valid !== 1'b0 || uart_rx_ready !== 1'b1 || irq_rx !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs rdata=%h txv=%b rxr=%b irq=%b exp 0/0/1/0", rdata, uart_tx_valid, uart_rx_ready, irq_rx);
      end
      rst = 1'b0;
      @(negedge clk);
      cpu_load(8'h00, d);
      checks++;
      if (d !== 32'h0000_0001) begin
         failures++; $display("FAIL reset_status got=%h exp=%h", d, 32'h0000_0001);
      end
   endtask

   task automatic test_tx_drop();
      logic [31:0] d;
      logic [7:0]  got [$];
      uart_tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) cpu_store(8'h08, 8'h41 + 8'(i));
      cpu_load(8'h00, d);
      checks++;
      if (d !== 32'h0000_0808) begin
         failures++; $display("FAIL tx_full_status got=%h exp=%h", d, 32'h0000_0808);
      end
      checks++;
      if (uart_tx_valid !== 1'b1 || uart_tx_data !== 8'h41) begin
         failures++; $display("FAIL tx_head valid=%b data=%h exp 1/41", uart_tx_valid, uart_tx_data);
      end
      uart_tx_ready = 1'b1;
      for (int c = 0; c < 20 && uart_tx_valid; c++) begin
         got.push_back(uart_tx_data);
         @(negedge clk);
      end
      uart_tx_ready = 1'b0;
      checks++;
      if (got.size() != 8) begin
         failures++; $display("FAIL tx_emit_count got=%0d exp=8", got.size());
      end
      for (int i = 0; i < got.size(); i++) begin
         checks++;
         if (got[i] !== 8'h41 + 8'(i)) begin
            failures++; $display("FAIL tx_emit_order idx=%0d got=%h exp=%h", i, got[i], 8'h41 + 8'(i));
         end
      end
      cpu_store(8'h0C, 8'h01);
      cpu_load(8'h00, d);
      checks++;
      if (d !== 32'h0000_0001) begin
         failures++; $display("FAIL tx_drop_clear got=%h exp=%h", d, 32'h0000_0001);
      end
   endtask

   task automatic test_rx_basic();
      logic [31:0] d;
      rx_send(8'h10, 3);
      checks++;
      if (irq_rx !== 1'b1) begin
         failures++; $display("FAIL rx_irq_high got=%b exp=1", irq_rx);
      end
      cpu_load(8'h00, d);
      checks++;
      if (d !== 32'h0003_0003) begin
         failures++; $display("FAIL rx_status3 got=%h exp=%h", d, 32'h0003_0003);
      end
      for (int i = 0; i < 3; i++) begin
         cpu_load(8'h04, d);
         checks++;
         if (d !== 32'h10 + 32'(i)) begin
            failures++; $display("FAIL rx_data idx=%0d got=%h exp=%h", i, d, 32'h10 + 32'(i));
         end
      end
      checks++;
      if (irq_rx !== 1'b0) begin
         failures++; $display("FAIL rx_irq_low got=%b exp=0", irq_rx);
      end
      cpu_store(8'h20, 8'hFF);
      checks++;
      if (rdata !== 32'h12) begin
         failures++; $display("FAIL rdata_hold got=%h exp=%h", rdata, 32'h12);
      end
      cpu_load(8'h04, d);
      checks++;
      if (d !== 32'h0) begin
         failures++; $display("FAIL rx_empty_read got=%h exp=0", d);
      end
      cpu_load(8'h08, d);
      checks++;
      if (d !== 32'h0) begin
         failures++; $display("FAIL txdata_read got=%h exp=0", d);
      end
   endtask

   task automatic test_rx_overflow();
      logic [31:0] d;
      rx_send(8'h30, 8);
      // Ninth byte arrives while the CPU clears flags: the new overflow must stick
      uart_rx_valid = 1'b1; uart_rx_data = 8'h38;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h0C; req_wdata = 8'h01;
      #1;
      checks++;
      if (uart_rx_ready !== 1'b0) begin
         failures++; $display("FAIL rx_ready_full got=%b exp=0", uart_rx_ready);
      end
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'b0; uart_rx_valid = 1'b0;
      cpu_load(8'h00, d);
      checks++;
      if (d !== 32'h0008_0007) begin
         failures++; $display("FAIL rx_ovf_status got=%h exp=%h", d, 32'h0008_0007);
      end
      cpu_store(8'h0C, 8'h01);
      cpu_load(8'h00, d);
      checks++;
      if (d !== 32'h0008_0003) begin
         failures++; $display("FAIL rx_ovf_clear got=%h exp=%h", d, 32'h0008_0003);
      end
      cpu_store(8'h0C, 8'h02);
      cpu_load(8'h00, d);
      checks++;
      if (d !== 32'h0000_0001 || irq_rx !== 1'b0) begin
         failures++; $display("FAIL rx_flush got=%h irq=%b exp=%h/0", d, irq_rx, 32'h0000_0001);
      end
   endtask

   task automatic test_rx_pop_push();
      logic [31:0] d;
      rx_send(8'h20, 8);
      uart_rx_valid = 1'b1; uart_rx_data = 8'h28;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h04;
      #1;
      checks++;
      if (uart_rx_ready !== 1'b1) begin
         failures++; $display("FAIL rx_ready_on_pop got=%b exp=1", uart_rx_ready);
      end
      @(negedge clk);
      req_valid = 1'b0; uart_rx_valid = 1'b0;
      checks++;
      if (rdata !== 32'h20) begin
         failures++; $display("FAIL rx_pop_push_data got=%h exp=%h", rdata, 32'h20);
      end
      cpu_load(8'h00, d);
      checks++;
      if (d !== 32'h0008_0003) begin
         failures++; $display("FAIL rx_pop_push_status got=%h exp=%h", d, 32'h0008_0003);
      end
      for (int i = 0; i < 8; i++) begin
         cpu_load(8'h04, d);
         checks++;
         if (d !== 32'h21 + 32'(i)) begin
            failures++; $display("FAIL rx_wrap_data idx=%0d got=%h exp=%h", i, d, 32'h21 + 32'(i));
         end
      end
   endtask

   task automatic test_flush_reset();
      logic [31:0] d;
      uart_tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) cpu_store(8'h08, 8'h60 + 8'(i));
      cpu_load(8'h00, d);
      checks++;
      if (d !== 32'h0000_0301) begin
         failures++; $display("FAIL tx3_status got=%h exp=%h", d, 32'h0000_0301);
      end
      // Flush lands together with a TX pop and an RX push
      uart_tx_ready = 1'b1; uart_rx_valid = 1'b1; uart_rx_data = 8'h77;
      cpu_store(8'h0C, 8'h02);
      uart_tx_ready = 1'b0; uart_rx_valid = 1'b0;
      checks++;
      if (uart_tx_valid !== 1'b0 || irq_rx !== 1'b0) begin
         failures++; $display("FAIL flush_outputs txv=%b irq=%b exp 0/0", uart_tx_valid, irq_rx);
      end
      cpu_load(8'h00, d);
      checks++;
      if (d !== 32'h0000_0001) begin
         failures++; $display("FAIL flush_status got=%h exp=%h", d, 32'h0000_0001);
      end
      cpu_store(8'h08, 8'h55);
      rx_send(8'h90, 1);
      cpu_load(8'h00, d);
      uart_tx_ready = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (rdata !== 32'h0 || uart_tx_valid !== 1'b0 || uart_rx_ready !== 1'b1 || irq_rx !== 1'b0) begin
         failures++;
         $display("FAIL async_reset rdata=%h txv=%b rxr=%b irq=%b exp 0/0/1/0", rdata, uart_tx_valid, uart_rx_ready, irq_rx);
      end
      uart_tx_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      cpu_load(8'h00, d);
      checks++;
      if (d !== 32'h0000_0001) begin
         failures++; $display("FAIL post_reset_status got=%h exp=%h", d, 32'h0000_0001);
      end
   endtask

   initial begin
      test_reset();
      test_tx_drop();
      test_rx_basic();
      test_rx_overflow();
      test_rx_pop_push();
      test_flush_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
